// File: rtl/axil_slave_regfile_if.sv
// rtl/axil_slave_regfile_if.sv - AXI4-Lite bundle between a bus master and the register file
interface axil_slave_regfile_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]     AWADDR;
   logic                      AWVALID;
   logic                      AWREADY;
   logic [DATA_WIDTH-1:0]     WDATA;
   logic [DATA_WIDTH/8-1:0]   WSTRB;
   logic                      WVALID;
   logic                      WREADY;
   logic [1:0]                BRESP;
   logic                      BVALID;
   logic                      BREADY;
   logic [ADDR_WIDTH-1:0]     ARADDR;
   logic                      ARVALID;
   logic                      ARREADY;
   logic [DATA_WIDTH-1:0]     RDATA;
   logic [1:0]                RRESP;
   logic                      RVALID;
   logic                      RREADY;

   modport master (
      output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
      input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );

   modport slave (
      input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
      output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );
endinterface

// File: rtl/axil_slave_regfile.sv
// rtl/axil_slave_regfile.sv - AXI4-Lite register file with byte strobes, read-only ID at index 0
// and SLVERR on decode misses; all registers exported on reg_out.
module axil_slave_regfile #(
   parameter int          ADDR_WIDTH = 32,
   parameter int          DATA_WIDTH = 32,
   parameter int          NUM_REGS   = 16,
   parameter logic [31:0] ID_VALUE   = 32'hA11E_0001
) (
   input  logic                           clk,
   input  logic                           ARESET,
   axil_slave_regfile_if.slave            bus,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);
   localparam int         IDX_W       = $clog2(NUM_REGS);
   localparam int         NSTRB       = DATA_WIDTH / 8;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic                  aw_held_q, w_held_q;
   logic [ADDR_WIDTH-1:0] awaddr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [NSTRB-1:0]      wstrb_q;
   logic                  bvalid_q, rvalid_q;
   logic [1:0]            bresp_q, rresp_q;
   logic [DATA_WIDTH-1:0] rdata_q;

   logic                  awready, wready, arready;
   logic                  aw_fire, w_fire, ar_fire, commit;
   logic [ADDR_WIDTH-1:0] waddr_d;
   logic [DATA_WIDTH-1:0] wdata_d;
   logic [NSTRB-1:0]      wstrb_d;
   logic [IDX_W-1:0]      widx, ridx;
   logic                  whit, rhit;
   logic                  unused_addr_lsbs;

   assign awready = !ARESET && !aw_held_q && !bvalid_q;
   assign wready  = !ARESET && !w_held_q && !bvalid_q;
   assign arready = !ARESET && !rvalid_q;

   assign aw_fire = bus.AWVALID && awready;
   assign w_fire  = bus.WVALID && wready;
   assign ar_fire = bus.ARVALID && arready;
   assign commit  = (aw_held_q || aw_fire) && (w_held_q || w_fire);

   // A held beat takes precedence; otherwise the live bus beat completes the pair.
   assign waddr_d = aw_held_q ? awaddr_q : bus.AWADDR;
   assign wdata_d = w_held_q ? wdata_q : bus.WDATA;
   assign wstrb_d = w_held_q ? wstrb_q : bus.WSTRB;

   assign widx = waddr_d[2 +: IDX_W];
   assign ridx = bus.ARADDR[2 +: IDX_W];
   assign whit = (waddr_d[ADDR_WIDTH-1:2+IDX_W] == '0);
   assign rhit = (bus.ARADDR[ADDR_WIDTH-1:2+IDX_W] == '0);
   assign unused_addr_lsbs = ^{waddr_d[1:0], bus.ARADDR[1:0]};

   assign bus.AWREADY = awready;
   assign bus.WREADY  = wready;
   assign bus.ARREADY = arready;
   assign bus.BVALID  = bvalid_q;
   assign bus.BRESP   = bresp_q;
   assign bus.RVALID  = rvalid_q;
   assign bus.RRESP   = rresp_q;
   assign bus.RDATA   = rdata_q;

   always_ff @(posedge clk) begin
      if (ARESET) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         rvalid_q  <= 1'b0;
         rresp_q   <= RESP_OKAY;
         rdata_q   <= '0;
      end else begin
         if (commit) begin
            if (whit && widx != '0) begin
               for (int b = 0; b < NSTRB; b++)
                  if (wstrb_d[b]) regs_q[widx][8*b +: 8] <= wdata_d[8*b +: 8];
               bresp_q <= RESP_OKAY;
            end else begin
               bresp_q <= RESP_SLVERR;
            end
            bvalid_q  <= 1'b1;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
         end else begin
            if (aw_fire) begin
               aw_held_q <= 1'b1;
               awaddr_q  <= bus.AWADDR;
            end
            if (w_fire) begin
               w_held_q <= 1'b1;
               wdata_q  <= bus.WDATA;
               wstrb_q  <= bus.WSTRB;
            end
            if (bvalid_q && bus.BREADY) bvalid_q <= 1'b0;
         end

         // regs_q is sampled before any same-edge commit lands, so reads see the old value.
         if (ar_fire) begin
            rdata_q  <= !rhit ? '0 : (ridx == '0) ? ID_VALUE : regs_q[ridx];
            rresp_q  <= rhit ? RESP_OKAY : RESP_SLVERR;
            rvalid_q <= 1'b1;
         end else if (rvalid_q && bus.RREADY) begin
            rvalid_q <= 1'b0;
         end
      end
   end

   always_comb begin
      reg_out = '0;
      for (int i = 1; i < NUM_REGS; i++) reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
      reg_out[DATA_WIDTH-1:0] = ID_VALUE;
   end
endmodule

// File: tb/tb_axil_slave_regfile.sv
// tb/tb_axil_slave_regfile.sv - directed bench for axil_slave_regfile with a transaction-level
// reference model checked every cycle.
module tb_axil_slave_regfile;
   localparam int          NREG = 16;
   localparam logic [31:0] ID   = 32'hA11E_0001;
   localparam int          W    = NREG * 32;

   typedef struct {
      logic [31:0] d;
      logic [1:0]  r;
   } rsp_t;

   logic          clk = 1'b0;
   logic          ARESET;
   logic [W-1:0]  reg_out;
   int            n_tests = 0;
   int            n_fail  = 0;

   axil_slave_regfile_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   axil_slave_regfile #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NREG), .ID_VALUE(ID)
   ) dut (
      .clk(clk),
      .ARESET(ARESET),
      .bus(bus),
      .reg_out(reg_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_w(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timed out at %0t", nm, $time);
   endtask

   // Reference model: register contents, pending beats and outstanding responses
   logic [31:0] m_regs [NREG];
   logic        m_known = 1'b0;
   logic        m_aw_held, m_w_held;
   logic [31:0] m_awaddr, m_wdata;
   logic [3:0]  m_wstrb;
   logic [1:0]  bq[$];
   rsp_t        rq[$];

   function automatic rsp_t model_read(input logic [31:0] a);
      rsp_t r;
      if (a >= NREG * 4) begin
         r.d = 32'h0;
         r.r = 2'b10;
      end else begin
         r.d = (a / 4 == 0) ? ID : m_regs[a / 4];
         r.r = 2'b00;
      end
      return r;
   endfunction

   function automatic logic [W-1:0] model_vec();
      logic [W-1:0] v;
      for (int i = 0; i < NREG; i++) v[i*32 +: 32] = (i == 0) ? ID : m_regs[i];
      return v;
   endfunction

   always @(negedge clk) begin
      logic exp_awr, exp_wr, exp_arr;
      rsp_t rr;
      int   idx;
      exp_awr = !ARESET && !m_aw_held && bq.size() == 0;
      exp_wr  = !ARESET && !m_w_held && bq.size() == 0;
      exp_arr = !ARESET && rq.size() == 0;
      chk("awready", {31'b0, bus.AWREADY}, {31'b0, exp_awr});
      chk("wready",  {31'b0, bus.WREADY},  {31'b0, exp_wr});
      chk("arready", {31'b0, bus.ARREADY}, {31'b0, exp_arr});
      if (m_known) begin
         chk("bvalid", {31'b0, bus.BVALID}, {31'b0, bq.size() != 0});
         if (bq.size() != 0) chk("bresp", {30'b0, bus.BRESP}, {30'b0, bq[0]});
         chk("rvalid", {31'b0, bus.RVALID}, {31'b0, rq.size() != 0});
         if (rq.size() != 0) begin
            chk("rdata", bus.RDATA, rq[0].d);
            chk("rresp", {30'b0, bus.RRESP}, {30'b0, rq[0].r});
         end
         chk_w("reg_out", reg_out, model_vec());
      end
      if (ARESET) begin
         for (int i = 0; i < NREG; i++) m_regs[i] = 32'h0;
         m_aw_held = 1'b0;
         m_w_held  = 1'b0;
         bq.delete();
         rq.delete();
         m_known = 1'b1;
      end else if (m_known) begin
         if (bq.size() != 0 && bus.BREADY) void'(bq.pop_front());
         if (rq.size() != 0 && bus.RREADY) void'(rq.pop_front());
         if (bus.ARVALID && exp_arr) begin
            rr = model_read(bus.ARADDR);
            rq.push_back(rr);
         end
         if (bus.AWVALID && exp_awr) begin
            m_aw_held = 1'b1;
            m_awaddr  = bus.AWADDR;
         end
         if (bus.WVALID && exp_wr) begin
            m_w_held = 1'b1;
            m_wdata  = bus.WDATA;
            m_wstrb  = bus.WSTRB;
         end
         if (m_aw_held && m_w_held) begin
            idx = int'(m_awaddr / 4);
            if (m_awaddr < NREG * 4 && idx != 0) begin
               for (int b = 0; b < 4; b++)
                  if (m_wstrb[b]) m_regs[idx][8*b +: 8] = m_wdata[8*b +: 8];
               bq.push_back(2'b00);
            end else begin
               bq.push_back(2'b10);
            end
            m_aw_held = 1'b0;
            m_w_held  = 1'b0;
         end
      end
   end

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_hold,
                            output logic [1:0] resp);
      bit aw_done = 0, w_done = 0;
      int t = 0;
      resp = 2'bxx;
      bus.AWADDR = addr;
      bus.WDATA  = data;
      bus.WSTRB  = strb;
      while (!(aw_done && w_done) && t < 50) begin
         bus.AWVALID = !aw_done && t >= aw_dly;
         bus.WVALID  = !w_done && t >= w_dly;
         @(negedge clk);
         if (w_done && !aw_done) chk("wready_while_held", {31'b0, bus.WREADY}, 32'd0);
         if (bus.AWVALID && bus.AWREADY) aw_done = 1;
         if (bus.WVALID && bus.WREADY) w_done = 1;
         @(posedge clk); #1;
         t++;
      end
      bus.AWVALID = 1'b0;
      bus.WVALID  = 1'b0;
      if (!(aw_done && w_done)) begin
         timeout("write_handshake");
         return;
      end
      @(negedge clk);
      chk("bvalid_latency", {31'b0, bus.BVALID}, 32'd1);
      if (!bus.BVALID) return;
      resp = bus.BRESP;
      repeat (b_hold) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("bvalid_hold", {31'b0, bus.BVALID}, 32'd1);
         chk("bresp_hold", {30'b0, bus.BRESP}, {30'b0, resp});
         chk("awready_hold", {31'b0, bus.AWREADY}, 32'd0);
         chk("wready_hold", {31'b0, bus.WREADY}, 32'd0);
      end
      @(posedge clk); #1;
      bus.BREADY = 1'b1;
      @(posedge clk); #1;
      bus.BREADY = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] addr, input int r_hold,
                           output logic [31:0] data, output logic [1:0] resp);
      bit done = 0;
      int t = 0;
      data = 32'hx;
      resp = 2'bxx;
      bus.ARADDR  = addr;
      bus.ARVALID = 1'b1;
      while (!done && t < 50) begin
         @(negedge clk);
         done = bus.ARVALID && bus.ARREADY;
         @(posedge clk); #1;
         t++;
      end
      bus.ARVALID = 1'b0;
      if (!done) begin
         timeout("read_handshake");
         return;
      end
      @(negedge clk);
      chk("rvalid_latency", {31'b0, bus.RVALID}, 32'd1);
      if (!bus.RVALID) return;
      data = bus.RDATA;
      resp = bus.RRESP;
      repeat (r_hold) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("rdata_hold", bus.RDATA, data);
         chk("arready_hold", {31'b0, bus.ARREADY}, 32'd0);
      end
      @(posedge clk); #1;
      bus.RREADY = 1'b1;
      @(posedge clk); #1;
      bus.RREADY = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d, d2;
      logic [1:0]  r, r2;
      ARESET = 1'b1;
      bus.AWADDR = '0; bus.AWVALID = 1'b0;
      bus.WDATA = '0;  bus.WSTRB = '0; bus.WVALID = 1'b0;
      bus.BREADY = 1'b0;
      bus.ARADDR = '0; bus.ARVALID = 1'b0;
      bus.RREADY = 1'b0;
      repeat (3) @(posedge clk);
      #1 ARESET = 1'b0;
      @(negedge clk);
      chk_w("reset_reg_out", reg_out, {{(W-32){1'b0}}, ID});
      chk("reset_bvalid", {31'b0, bus.BVALID}, 32'd0);
      @(posedge clk); #1;

      axi_read(32'h00, 0, d, r);
      chk("id_rdata", d, 32'hA11E_0001);
      chk("id_rresp", {30'b0, r}, 32'd0);
      axi_read(32'h04, 0, d, r);
      chk("r1_reset", d, 32'h0);
      chk("r1_rresp", {30'b0, r}, 32'd0);

      axi_write(32'h08, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, r);
      chk("w2_bresp", {30'b0, r}, 32'd0);
      axi_read(32'h08, 0, d, r);
      chk("r2_full", d, 32'hDEAD_BEEF);

      axi_write(32'h08, 32'h1122_3344, 4'b0101, 3, 0, 0, r);
      chk("w2_strb_bresp", {30'b0, r}, 32'd0);
      axi_read(32'h08, 0, d, r);
      chk("r2_strb", d, 32'hDE22_BE44);
      axi_read(32'h0A, 0, d, r);
      chk("r2_lsb_ignored", d, 32'hDE22_BE44);

      axi_write(32'h40, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, r);
      chk("miss_bresp", {30'b0, r}, 32'd2);
      chk("miss_slot2", reg_out[2*32 +: 32], 32'hDE22_BE44);
      axi_write(32'h00, 32'h1234_5678, 4'hF, 0, 0, 0, r);
      chk("id_write_bresp", {30'b0, r}, 32'd2);
      chk("id_slot0", reg_out[31:0], 32'hA11E_0001);
      axi_read(32'h40, 0, d, r);
      chk("miss_rdata", d, 32'h0);
      chk("miss_rresp", {30'b0, r}, 32'd2);

      axi_write(32'h08, 32'h0, 4'h0, 0, 0, 0, r);
      chk("nostrb_bresp", {30'b0, r}, 32'd0);
      chk("nostrb_slot2", reg_out[2*32 +: 32], 32'hDE22_BE44);
      axi_write(32'h3C, 32'hAB00_00CD, 4'b1000, 0, 2, 0, r);
      axi_read(32'h3C, 0, d, r);
      chk("top_reg", d, 32'hAB00_0000);

      axi_write(32'h10, 32'hCAFE_F00D, 4'hF, 0, 0, 5, r);
      chk("bhold_bresp", {30'b0, r}, 32'd0);
      axi_read(32'h10, 4, d, r);
      chk("rhold_rdata", d, 32'hCAFE_F00D);

      fork
         axi_write(32'h08, 32'h0000_0000, 4'hF, 0, 0, 0, r);
         axi_read(32'h08, 0, d2, r2);
      join
      chk("same_edge_read_old", d2, 32'hDE22_BE44);
      axi_read(32'h08, 0, d, r);
      chk("same_edge_after", d, 32'h0);

      bus.AWADDR = 32'h0C; bus.WDATA = 32'h5; bus.WSTRB = 4'hF;
      bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
      @(posedge clk); #1;
      bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
      @(negedge clk);
      chk("pre_reset_bvalid", {31'b0, bus.BVALID}, 32'd1);
      chk("pre_reset_slot3", reg_out[3*32 +: 32], 32'h5);
      @(posedge clk); #1;
      ARESET = 1'b1;
      @(negedge clk);
      chk("reset_awready", {31'b0, bus.AWREADY}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("post_reset_bvalid", {31'b0, bus.BVALID}, 32'd0);
      chk("post_reset_slot3", reg_out[3*32 +: 32], 32'h0);
      chk("reset_awready2", {31'b0, bus.AWREADY}, 32'd0);
      @(posedge clk); #1;
      ARESET = 1'b0;
      @(negedge clk);
      chk("release_awready", {31'b0, bus.AWREADY}, 32'd1);
      @(posedge clk); #1;
      axi_read(32'h10, 0, d, r);
      chk("post_reset_r4", d, 32'h0);

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
